// File: rtl/adc_snapshot_ctrl.sv
// adc_snapshot_ctrl
//   Sys-clock sequencer for the LVDS ADC capture frontend. A CSR start waits
//   for the frontend lane-aligned flag (with an optional timeout), then raises
//   stream_enable and gates exactly snap_len AXIS beats from the frontend to
//   the consumer, marking the final one with m_last. Continuous mode streams
//   until aborted. Status (busy, snapshot_done, snap_err, beat_count) is
//   reported back to the CSR block.
//
// Ports
//   sys_clk, sys_rst_n     : clock, synchronous active-low reset
//   start, abort           : CSR pulses
//   cont_mode              : 1 = unbounded streaming (sampled on start)
//   snap_len               : beats per snapshot (sampled on start)
//   align_timeout          : alignment wait limit in cycles, 0 = forever
//   aligned_async          : sticky aligned flag from the DCO domain
//   stream_enable          : enable to the frontend AXIS output stage
//   s_data/s_valid/s_ready : upstream AXIS beat
//   m_data/m_valid/m_ready/m_last : downstream AXIS beat
//   busy, snapshot_done, snap_err, beat_count : CSR status
module adc_snapshot_ctrl #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cont_mode,
  input  logic [31:0]       snap_len,
  input  logic [TMO_W-1:0]  align_timeout,
  input  logic              aligned_async,
  output logic              stream_enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              snapshot_done,
  output logic              snap_err,
  output logic [31:0]       beat_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_ALIGN = 3'd1,
    STREAM     = 3'd2,
    DONE       = 3'd3,
    ERR        = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               aligned_s;
  logic [31:0]        len_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               cont_q;
  logic               accept;
  logic               beat;

  // Saturating beat counter increment; only reachable in continuous mode.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Alignment flag synchroniser: the only crossing from the DCO domain.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], aligned_async};
    end
  end

  assign aligned_s = sync_q[SYNC_STAGES-1];

  // abort masks start in every state, even where abort itself does nothing.
  assign accept = start && !abort &&
                  ((state == IDLE) || (state == DONE) || (state == ERR));
  assign beat   = m_valid && m_ready;
  assign m_data = s_data;
  assign busy   = (state == WAIT_ALIGN) || (state == STREAM);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    m_valid    = 1'b0;
    s_ready    = 1'b0;
    m_last     = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (accept) begin
          state_next = (!cont_mode && (snap_len == 32'd0)) ? DONE : WAIT_ALIGN;
        end
      end
      WAIT_ALIGN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (aligned_s) begin
          state_next = STREAM;
        end else if ((tmo_q != '0) && (tmo_cnt == tmo_q - TMO_W'(1))) begin
          state_next = ERR;
        end
      end
      STREAM: begin
        m_valid = s_valid;
        s_ready = m_ready;
        m_last  = !cont_q && s_valid && (beat_count == len_q - 32'd1);
        if (abort) begin
          state_next = IDLE;
        end else if (s_valid && m_ready && m_last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture parameters: only meaningful after an accepted start.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      len_q <= snap_len;
      tmo_q <= align_timeout;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      stream_enable <= 1'b0;
      snapshot_done <= 1'b0;
      snap_err      <= 1'b0;
      beat_count    <= 32'd0;
      tmo_cnt       <= '0;
      cont_q        <= 1'b0;
    end else begin
      stream_enable <= (state_next == STREAM);
      if (accept) begin
        cont_q        <= cont_mode;
        beat_count    <= 32'd0;
        tmo_cnt       <= '0;
        snap_err      <= 1'b0;
        // Zero-length snapshots complete immediately.
        snapshot_done <= (state_next == DONE);
      end else begin
        if (state == WAIT_ALIGN) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        if ((state == STREAM) && beat) begin
          beat_count <= sat_inc(beat_count);
        end
        if ((state == STREAM) && (state_next == DONE)) begin
          snapshot_done <= 1'b1;
        end
        if (state_next == ERR) begin
          snap_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_snapshot_ctrl.sv
module tb_adc_snapshot_ctrl;

  localparam int DATA_W = 16;
  localparam int TMO_W  = 24;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              cont_mode = 1'b0;
  logic [31:0]       snap_len = 32'd0;
  logic [TMO_W-1:0]  align_timeout = '0;
  logic              aligned_async = 1'b1;
  logic              stream_enable;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic              snapshot_done;
  logic              snap_err;
  logic [31:0]       beat_count;

  int checks = 0;
  int failures = 0;
  int beats, lasts, last_beat, en_cyc, held, bad, cyc;

  adc_snapshot_ctrl #(.DATA_W(DATA_W), .SYNC_STAGES(2), .TMO_W(TMO_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .cont_mode(cont_mode), .snap_len(snap_len), .align_timeout(align_timeout),
    .aligned_async(aligned_async), .stream_enable(stream_enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .snapshot_done(snapshot_done), .snap_err(snap_err),
    .beat_count(beat_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Drives the capture cycle by cycle while busy and tallies what the
  // downstream side observes. Negative *_at arguments disable that action.
  task automatic run(input string tag, input int max, input bit toggle,
                     input int start_at, input int abort_beats, input int rst_at);
    bit aborted = 1'b0;
    beats = 0; lasts = 0; last_beat = 0; en_cyc = 0; held = 0; bad = 0; cyc = 0;
    while (busy && cyc < max) begin
      if (toggle) m_ready = ((cyc % 2) == 1);
      start = (cyc == start_at);
      abort = 1'b0;
      if (abort_beats >= 0 && beats == abort_beats && !aborted) begin
        abort = 1'b1;
        m_ready = 1'b0;
        aborted = 1'b1;
      end
      sys_rst_n = (cyc != rst_at);
      s_data = DATA_W'(cyc * 37 + 5);
      #1;
      if (m_valid && m_ready) begin
        beats++;
        if (m_last) begin
          lasts++;
          last_beat = beats;
        end
      end
      if (m_last && !m_ready) held++;
      if (stream_enable) en_cyc++;
      if (m_valid !== (stream_enable & s_valid)) bad++;
      if (s_ready !== (stream_enable & m_ready)) bad++;
      if (m_data !== s_data) bad++;
      step(1);
      cyc++;
    end
    check_val({tag, "_bounded"}, (cyc < max) ? 1 : 0, 1);
    start = 1'b0;
    abort = 1'b0;
    sys_rst_n = 1'b1;
    m_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    s_valid = 1'b1;
    m_ready = 1'b1;
    step(3);
    check_val("rst_stream_enable", stream_enable, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", snapshot_done, 0);
    check_val("rst_err", snap_err, 0);
    check_val("rst_beat_count", beat_count, 0);
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_s_ready", s_ready, 0);
    sys_rst_n = 1'b1;
    step(4);

    // Basic snapshot of 8 beats
    snap_len = 32'd8;
    pulse_start();
    check_val("basic_wait_busy", busy, 1);
    check_val("basic_wait_en", stream_enable, 0);
    run("basic", 50, 1'b0, -1, -1, -1);
    check_val("basic_beats", beats, 8);
    check_val("basic_lasts", lasts, 1);
    check_val("basic_last_beat", last_beat, 8);
    check_val("basic_en_cycles", en_cyc, 8);
    check_val("basic_cycles", cyc, 9);
    check_val("basic_gating", bad, 0);
    check_val("basic_beat_count", beat_count, 8);
    check_val("basic_done", snapshot_done, 1);
    check_val("basic_m_valid_after", m_valid, 0);
    check_val("basic_en_after", stream_enable, 0);

    // Backpressure: m_ready toggles every cycle
    snap_len = 32'd5;
    pulse_start();
    run("bp", 50, 1'b1, -1, -1, -1);
    check_val("bp_beats", beats, 5);
    check_val("bp_lasts", lasts, 1);
    check_val("bp_last_beat", last_beat, 5);
    check_val("bp_last_held", held, 1);
    check_val("bp_cycles", cyc, 10);
    check_val("bp_gating", bad, 0);
    check_val("bp_beat_count", beat_count, 5);

    // Alignment timeout after 100 cycles
    aligned_async = 1'b0;
    step(4);
    snap_len = 32'd4;
    align_timeout = TMO_W'(100);
    pulse_start();
    run("tmo", 300, 1'b0, -1, -1, -1);
    check_val("tmo_wait_cycles", cyc, 100);
    check_val("tmo_en_cycles", en_cyc, 0);
    check_val("tmo_err", snap_err, 1);
    check_val("tmo_done", snapshot_done, 0);
    check_val("tmo_beat_count", beat_count, 0);
    aligned_async = 1'b1;
    step(4);
    check_val("tmo_err_held", snap_err, 1);
    snap_len = 32'd3;
    pulse_start();
    check_val("tmo_err_cleared", snap_err, 0);
    run("retry", 50, 1'b0, -1, -1, -1);
    check_val("retry_beats", beats, 3);
    check_val("retry_last_beat", last_beat, 3);
    check_val("retry_done", snapshot_done, 1);

    // Zero-length snapshot
    snap_len = 32'd0;
    pulse_start();
    check_val("zero_done", snapshot_done, 1);
    check_val("zero_busy", busy, 0);
    check_val("zero_beat_count", beat_count, 0);
    step(1);
    check_val("zero_en", stream_enable, 0);

    // start pulsed mid-STREAM is ignored
    snap_len = 32'd6;
    pulse_start();
    run("ign", 50, 1'b0, 3, -1, -1);
    check_val("ign_beats", beats, 6);
    check_val("ign_beat_count", beat_count, 6);
    check_val("ign_cycles", cyc, 7);
    check_val("ign_done", snapshot_done, 1);

    // Continuous mode aborted after 37 beats; cont_mode sampled only at start
    cont_mode = 1'b1;
    snap_len = 32'd5;
    pulse_start();
    cont_mode = 1'b0;
    run("abort", 200, 1'b0, -1, 37, -1);
    check_val("abort_beats", beats, 37);
    check_val("abort_lasts", lasts, 0);
    check_val("abort_en_cycles", en_cyc, 38);
    check_val("abort_beat_count", beat_count, 37);
    check_val("abort_done", snapshot_done, 0);
    check_val("abort_err", snap_err, 0);
    check_val("abort_en_after", stream_enable, 0);
    check_val("abort_busy_after", busy, 0);

    // abort and start together: start ignored
    snap_len = 32'd4;
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check_val("both_busy", busy, 0);
    check_val("both_beat_count", beat_count, 37);
    step(1);
    check_val("both_busy_later", busy, 0);

    // Reset mid-STREAM
    snap_len = 32'd10;
    pulse_start();
    run("rst", 50, 1'b0, -1, -1, 4);
    check_val("rst_mid_lasts", lasts, 0);
    check_val("rst_mid_beat_count", beat_count, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_en", stream_enable, 0);
    check_val("rst_mid_done", snapshot_done, 0);
    check_val("rst_mid_m_valid", m_valid, 0);
    check_val("rst_mid_m_last", m_last, 0);
    step(4);
    snap_len = 32'd3;
    pulse_start();
    run("post_rst", 50, 1'b0, -1, -1, -1);
    check_val("post_rst_beats", beats, 3);
    check_val("post_rst_last_beat", last_beat, 3);
    check_val("post_rst_beat_count", beat_count, 3);
    check_val("post_rst_done", snapshot_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_snapshot_ctrl.md
Name: adc_snapshot_ctrl

Overview:
- Sys-clock-domain sequencer for the LVDS ADC capture frontend.
- On a CSR start, waits for lane alignment (with timeout), then raises stream_enable and passes exactly snap_len AXIS beats through a gated valid/ready stage, tagging the final beat with m_last.
- Reports snapshot_done, snap_err and a live beat count back to CSR; also supports continuous (unbounded) mode.
- Sits between the frontend AXIS output stage and the downstream consumer.

Parameters:
- DATA_W, 16, AXIS data width (2*LANES).
- SYNC_STAGES, 2, flop stages synchronising aligned_async into sys_clk (min 2).
- TMO_W, 24, width of alignment-timeout counter and of the align_timeout input.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- start  in  1  CSR pulse; begin a capture.
- abort  in  1  CSR pulse; cancel any active capture.
- cont_mode  in  1  1 = continuous streaming (snap_len ignored).
- snap_len  in  32  beats per snapshot; latched on accepted start.
- align_timeout  in  TMO_W  cycles to wait for alignment; 0 = wait forever. Latched on start.
- aligned_async  in  1  frontend aligned flag (DCO domain, sticky).
- stream_enable  out  1  enable to frontend AXIS output stage.
- s_data  in  DATA_W  upstream beat data.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- m_data  out  DATA_W  downstream data (= s_data).
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  final beat of snapshot.
- busy  out  1  state is WAIT_ALIGN or STREAM.
- snapshot_done  out  1  sticky; snapshot completed.
- snap_err  out  1  sticky; alignment timeout.
- beat_count  out  32  beats transferred in current/last capture.

Behaviour:
- Reset (sys_rst_n=0 at clock edge): state=IDLE; stream_enable, busy, snapshot_done, snap_err = 0; beat_count=0; sync chain=0. Reset mid-capture aborts immediately; no m_last is issued.
- Synchroniser: aligned_s = aligned_async after SYNC_STAGES flops. It is the only signal read from the DCO domain.
- States: IDLE, WAIT_ALIGN, STREAM, DONE, ERR.
- Start acceptance:
  - start is accepted only in IDLE, DONE or ERR; it is ignored while busy.
  - On accept: latch len_q and tmo_q; clear beat_count, snapshot_done, snap_err and tmo counter; next state WAIT_ALIGN.
  - If !cont_mode and snap_len==0: go directly to DONE (snapshot_done=1 next cycle; no beats; stream_enable never rises).
- WAIT_ALIGN:
  - tmo counter increments each cycle.
  - If aligned_s==1: go to STREAM next cycle.
  - Else if tmo_q!=0 and counter==tmo_q-1: go to ERR (snap_err=1).
  - aligned_s takes priority when both conditions hold in the same cycle.
- STREAM:
  - stream_enable=1 (registered: high from the first STREAM cycle, low from the first cycle after leaving).
  - m_valid=s_valid and s_ready=m_ready, combinational, only while in STREAM; both are 0 in every other state. m_data=s_data always.
  - Beat: m_valid&&m_ready; beat_count increments by 1 per beat.
  - Snapshot mode: m_last = m_valid && (beat_count==len_q-1). A beat with m_last set moves the state to DONE; no further beat can be accepted.
  - Continuous mode: m_last=0; beat_count saturates at 0xFFFF_FFFF; leaves STREAM only via abort.
  - aligned_s dropping during STREAM is ignored (status-only).
- DONE: snapshot_done=1 and held until the next accepted start or reset.
- ERR: snap_err=1 and held until the next accepted start or reset.
- abort: from WAIT_ALIGN or STREAM, go to IDLE next cycle. snapshot_done/snap_err are not set; beat_count holds. abort is a no-op in other states. abort and start in the same cycle: abort wins and start is ignored.
- cont_mode is sampled at start only.
- busy is a combinational decode of state.

Test Plan:
- Basic snapshot: aligned_async=1, snap_len=8, start, m_ready=1, s_valid=1 -> stream_enable high for 8 beats, m_last only on beat 8, beat_count=8, snapshot_done=1, then m_valid=0.
- Backpressure: snap_len=5, m_ready toggling 1/0 every cycle -> exactly 5 handshakes; s_ready mirrors m_ready; m_last held with data while m_ready=0.
- Alignment timeout: aligned_async=0, align_timeout=100, start -> ERR after 100 cycles, snap_err=1, stream_enable never high. Then raise aligned_async and restart -> normal completion, snap_err cleared.
- Zero length / ignored start: snap_len=0 -> snapshot_done next cycle, 0 beats. start pulsed mid-STREAM -> no effect on count.
- Abort: continuous mode, abort after 37 beats -> IDLE, stream_enable low next cycle, beat_count=37, snapshot_done=0. abort+start in the same cycle -> stays IDLE.
- Reset mid-STREAM: sys_rst_n low for 1 cycle -> all outputs 0, no m_last; a subsequent start (snap_len=3) completes normally.
